dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS: ramps the frequency word from f_start to f_stop
// in dwell-timed steps. Define DDS_SWEEP_TRI_EN to add a return leg (triangle sweep).
module dds_sweep_ctrl #(
  parameter int PW = 32,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [PW-1:0] f_start,
  input  logic signed [PW-1:0] f_stop,
  input  logic        [PW-1:0] f_step,
  input  logic        [CW-1:0] dwell,
  input  logic signed [PW-1:0] phase_in,
  output logic signed [PW-1:0] freq,
  output logic signed [PW-1:0] phase,
  output logic                 dds_en,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [PW-1:0] cfg_start;
  logic signed [PW-1:0] cfg_stop;
  logic        [PW-1:0] cfg_step;
  logic        [CW-1:0] cfg_dwell;
  logic                 cfg_inc;
  logic        [CW-1:0] cnt;

  logic signed [PW-1:0] tgt;
  logic                 inc;
  logic        [CW-1:0] last;
  logic                 expire;
  logic                 degenerate;
  logic                 leg_end;
  logic                 load;
  logic                 turn;
  logic                 sweeping;

  // Step toward tgt with headroom above PW bits, then clamp so the ramp never passes tgt.
  function automatic logic signed [PW-1:0] step_clamp(
    input logic signed [PW-1:0] cur,
    input logic        [PW-1:0] stp,
    input logic signed [PW-1:0] lim,
    input logic                 up
  );
    logic signed [PW+1:0] c, s, t, n;
    c = {{2{cur[PW-1]}}, cur};
    s = {2'b00, stp};
    t = {{2{lim[PW-1]}}, lim};
    n = up ? (c + s) : (c - s);
    if (up ? (n > t) : (n < t))
      return lim;
    else
      return n[PW-1:0];
  endfunction

  always_comb begin
`ifdef DDS_SWEEP_TRI_EN
    tgt = (state == DOWN) ? cfg_start : cfg_stop;
    inc = (state == DOWN) ? !cfg_inc : cfg_inc;
`else
    tgt = cfg_stop;
    inc = cfg_inc;
`endif
    last       = (cfg_dwell == '0) ? '0 : (cfg_dwell - CW'(1));
    expire     = (cnt == last);
    degenerate = (cfg_step == '0) || (cfg_start == cfg_stop);
    leg_end    = expire && ((freq == tgt) || degenerate);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    turn      = 1'b0;
    busy      = 1'b0;
    dds_en    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = UP;
          load      = 1'b1;
        end
      end
      UP: begin
        busy   = 1'b1;
        dds_en = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (leg_end) begin
`ifdef DDS_SWEEP_TRI_EN
          if (!degenerate) begin
            state_nxt = DOWN;
            turn      = 1'b1;
          end else begin
            state_nxt = FIN;
          end
`else
          state_nxt = FIN;
`endif
        end
      end
`ifdef DDS_SWEEP_TRI_EN
      DOWN: begin
        busy   = 1'b1;
        dds_en = 1'b1;
        if (abort)
          state_nxt = IDLE;
        else if (leg_end)
          state_nxt = FIN;
      end
`endif
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sweeping = (state == UP) || (state == DOWN);

  // Datapath: configuration latch, dwell counter and frequency ramp.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
      cfg_inc   <= 1'b0;
      cnt       <= '0;
      freq      <= '0;
      phase     <= '0;
    end else if (load) begin
      cfg_start <= f_start;
      cfg_stop  <= f_stop;
      cfg_step  <= f_step;
      cfg_dwell <= dwell;
      cfg_inc   <= (f_stop >= f_start);
      cnt       <= '0;
      freq      <= f_start;
      phase     <= phase_in;
    end else if (sweeping && !abort) begin
      if (expire) begin
        cnt <= '0;
        if (turn)
          freq <= step_clamp(freq, cfg_step, cfg_start, !cfg_inc);
        else if (!leg_end)
          freq <= step_clamp(freq, cfg_step, tgt, inc);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps against a list-based reference model.
module tb_dds_sweep_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;
  localparam int W  = 2 * PW + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic signed [PW-1:0] f_start;
  logic signed [PW-1:0] f_stop;
  logic        [PW-1:0] f_step;
  logic        [CW-1:0] dwell;
  logic signed [PW-1:0] phase_in;
  logic signed [PW-1:0] freq;
  logic signed [PW-1:0] phase;
  logic                 dds_en;
  logic                 busy;
  logic                 done;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_q[$];

  dds_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .phase_in(phase_in),
    .freq    (freq),
    .phase   (phase),
    .dds_en  (dds_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] ef, input logic [PW-1:0] ep,
                     input logic ee, input logic eb, input logic ed);
    logic [W-1:0] obs, expv;
    obs  = {freq, phase, dds_en, busy, done};
    expv = {ef, ep, ee, eb, ed};
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed freq=%h phase=%h en/busy/done=%b required freq=%h phase=%h en/busy/done=%b",
             tag, obs[W-1:PW+3], obs[PW+2:3], obs[2:0], expv[W-1:PW+3], expv[PW+2:3], expv[2:0]);
    end
  endtask

  // Reference: the ordered list of distinct frequency words a sweep visits.
  function automatic void build(input longint s, input longint e, input longint stp);
    longint v;
    bit     up;
    exp_q.delete();
    up = (e >= s);
    v  = s;
    exp_q.push_back(v);
    while (v != e && stp != 0) begin
      if (up) v = (v + stp > e) ? e : v + stp;
      else    v = (v - stp < e) ? e : v - stp;
      exp_q.push_back(v);
    end
`ifdef DDS_SWEEP_TRI_EN
    if (stp != 0 && s != e) begin
      while (v != s) begin
        if (up) v = (v - stp < s) ? s : v - stp;
        else    v = (v + stp > s) ? s : v + stp;
        exp_q.push_back(v);
      end
    end
`endif
  endfunction

  task automatic scramble_cfg();
    f_start  = $urandom;
    f_stop   = $urandom;
    f_step   = $urandom;
    dwell    = CW'($urandom);
    phase_in = $urandom;
  endtask

  task automatic run_sweep(input string tag, input longint s, input longint e, input longint stp,
                           input int dw, input int abort_at, input int rst_at);
    int                   d;
    int                   total;
    logic [PW-1:0]        ph;
    logic [PW-1:0]        lastf;
    d  = (dw == 0) ? 1 : dw;
    ph = $urandom;
    build(s, e, stp);
    total = exp_q.size() * d;
    @(negedge clk);
    f_start  = s[PW-1:0];
    f_stop   = e[PW-1:0];
    f_step   = stp[PW-1:0];
    dwell    = CW'(dw);
    phase_in = ph;
    start    = 1'b1;
    abort    = 1'b0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      lastf = exp_q[k / d][PW-1:0];
      chk($sformatf("%s_c%0d", tag, k), lastf, ph, 1'b1, 1'b1, 1'b0);
      if (k == abort_at) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({tag, "_abort"}, lastf, ph, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk({tag, "_abort_idle"}, lastf, ph, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      if (k == rst_at) begin
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst"}, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk({tag, "_rst_idle"}, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      start = 1'(($urandom % 2));
      scramble_cfg();
    end
    lastf = exp_q[exp_q.size() - 1][PW-1:0];
    @(negedge clk);
    chk({tag, "_fin"}, lastf, ph, 1'b0, 1'b1, 1'b1);
    start = 1'(($urandom % 2));
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle"}, lastf, ph, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    longint rs, re, rp;
    logic [PW-1:0] hold_f, hold_p;
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    f_start  = 32'sd123;
    f_stop   = 32'sd456;
    f_step   = 32'd7;
    dwell    = 16'd2;
    phase_in = 32'h55;
    repeat (3) @(negedge clk);
    chk("reset", '0, '0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("reset_release", '0, '0, 1'b0, 1'b0, 1'b0);

    run_sweep("up_3dw",   100, 400, 100, 3, -1, -1);
    run_sweep("clamp",    0,   250, 100, 2, -1, -1);
    run_sweep("down_dw0", 500, 200, 150, 0, -1, -1);
    run_sweep("nowrap",   64'h7FFFFF00, 64'h7FFFFFFF, 64'h200, 1, -1, -1);
    run_sweep("step0",    -40, 300, 0,   2, -1, -1);
    run_sweep("eq",       77,  77,  10,  3, -1, -1);
    run_sweep("neg",      -300, -1000, 250, 1, -1, -1);
    run_sweep("abort",    100, 400, 100, 3, 4, -1);

    hold_f = freq;
    hold_p = phase;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    f_start = 32'sd999;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", hold_f, hold_p, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("start_abort_idle2", hold_f, hold_p, 1'b0, 1'b0, 1'b0);

`ifdef DDS_SWEEP_TRI_EN
    run_sweep("tri",      0, 200, 100, 1, -1, -1);
    run_sweep("tri_rst",  0, 200, 100, 1, -1, 3);
`else
    run_sweep("mid_rst",  0, 200, 100, 2, -1, 3);
`endif

    for (int i = 0; i < 12; i++) begin
      rs = longint'($urandom_range(0, 2000)) - 1000;
      re = longint'($urandom_range(0, 2000)) - 1000;
      rp = (($urandom % 5) == 0) ? 0 : longint'($urandom_range(50, 600));
      run_sweep($sformatf("rnd%0d", i), rs, re, rp, int'($urandom_range(0, 3)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
